// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its buffer.
package inst_fetch_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned INST_W      = 32;
  localparam int unsigned WORD_ADDR_W = ADDR_W - 2;
  localparam int unsigned FB_DEPTH    = 2;
  localparam int unsigned PTR_W       = $clog2(FB_DEPTH);
  localparam int unsigned CNT_W       = $clog2(FB_DEPTH + 1);

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0040_0000;

  // One buffered fetch: byte address and the word read from it.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/inst_fetch_fetch_buffer.sv
// Two-entry FIFO of fetch entries with flush; head entry and valid are registered.
module fetch_buffer
  import inst_fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  fetch_entry_t     i_entry,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_count,
  output logic             o_valid,
  output fetch_entry_t     o_head
);

  fetch_entry_t     r_mem     [FB_DEPTH];
  fetch_entry_t     w_mem_nxt [FB_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] w_rd_nxt;
  logic [PTR_W-1:0] w_wr_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_valid;
  fetch_entry_t     r_head;
  logic             w_pop;
  logic             w_push;

  // Guard against underflow and overflow regardless of what the caller asks for.
  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count < CNT_W'(FB_DEPTH)) || w_pop);

  always_comb begin
    w_mem_nxt   = r_mem;
    w_rd_nxt    = r_rd_ptr;
    w_wr_nxt    = r_wr_ptr;
    w_count_nxt = r_count;
    if (i_flush) begin
      w_rd_nxt    = '0;
      w_wr_nxt    = '0;
      w_count_nxt = '0;
    end else begin
      if (w_push) begin
        w_mem_nxt[r_wr_ptr] = i_entry;
        w_wr_nxt            = r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        w_rd_nxt = r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CNT_W'(1);
        2'b01:   w_count_nxt = r_count - CNT_W'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Head is precomputed from next state so outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FB_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_head   <= '0;
    end else begin
      r_mem    <= w_mem_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_wr_ptr <= w_wr_nxt;
      r_count  <= w_count_nxt;
      r_valid  <= (w_count_nxt != '0);
      r_head   <= w_mem_nxt[w_rd_nxt];
    end
  end

  assign o_count = r_count;
  assign o_valid = r_valid;
  assign o_head  = r_head;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC register, push/redirect control, and a 2-deep fetch buffer.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [WORD_ADDR_W-1:0] read_addr,
  input  logic [INST_W-1:0]      memout,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   inst_valid,
  output logic [INST_W-1:0]      inst,
  output logic [ADDR_W-1:0]      inst_pc,
  input  logic                   inst_ready
);

  logic [ADDR_W-1:0] r_pc;
  logic [CNT_W-1:0]  w_count;
  logic              w_valid;
  logic              w_pop;
  logic              w_push;
  fetch_entry_t      w_entry;
  fetch_entry_t      w_head;

  // Memory read is combinational, so the word for pc is available this cycle.
  assign read_addr = r_pc[ADDR_W-1:2];
  assign w_entry   = '{pc: r_pc, inst: memout};

  assign w_pop  = w_valid && inst_ready;
  assign w_push = !redirect_valid && ((w_count < CNT_W'(FB_DEPTH)) || w_pop);

  // Redirect wins over sequential advance; pc wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= align_word(redirect_pc);
    end else if (w_push) begin
      r_pc <= r_pc + ADDR_W'(4);
    end
  end

  fetch_buffer u_fetch_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_count (w_count),
    .o_valid (w_valid),
    .o_head  (w_head)
  );

  assign inst_valid = w_valid;
  assign inst       = w_head.inst;
  assign inst_pc    = w_head.pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboarded bench: decode must see a gap-free +4 stream restarting at each redirect/reset.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [29:0] read_addr;
  logic [31:0] memout;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  fetch_entry_t q_exp[$];
  logic         prev_ok = 1'b0;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .read_addr      (read_addr),
    .memout         (memout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  // Instruction memory: three fixed words at reset PC, a bijective hash elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0040_0000: return 32'h2008_0001;
      32'h0040_0004: return 32'h2009_0002;
      32'h0040_0008: return 32'h0109_5020;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  assign memout = mem_word({read_addr, 2'b00});

  function automatic fetch_entry_t mk(input logic [31:0] pc);
    return '{pc: pc, inst: mem_word(pc)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic rebuild(input logic [31:0] start);
    q_exp.delete();
    for (int i = 0; i < 8; i++) q_exp.push_back(mk(start + 32'(4 * i)));
  endtask

  task automatic extend();
    while (q_exp.size() < 8) q_exp.push_back(mk(q_exp[$].pc + 32'd4));
  endtask

  // Monitor: compare each accepted instruction against the expected stream.
  always @(negedge clk) begin
    fetch_entry_t e;
    if (!rst_n) begin
      chk("rst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst_pc", inst_pc, 32'd0);
      rebuild(RPC);
      prev_ok = 1'b0;
    end else begin
      if (prev_ok) chk("fetch_progress", 32'(inst_valid), 32'd1);
      if (inst_valid && inst_ready) begin
        if (q_exp.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          e = q_exp.pop_front();
          chk("sb_pc", inst_pc, e.pc);
          chk("sb_inst", inst, e.inst);
          extend();
        end
      end
      if (redirect_valid) begin
        rebuild({redirect_pc[31:2], 2'b00});
        prev_ok = 1'b0;
      end else begin
        prev_ok = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    for (int k = 0; k < 8 && !inst_valid; k++) step();
    chk("wait_valid", 32'(inst_valid), 32'd1);
  endtask

  initial begin
    logic [29:0] ra0;
    logic        r;

    // Reset state
    repeat (2) step();
    chk("reset_valid", 32'(inst_valid), 32'd0);
    chk("reset_inst", inst, 32'd0);
    chk("reset_inst_pc", inst_pc, 32'd0);
    chk("reset_read_addr", 32'(read_addr), 32'h0010_0000);

    // Straight-line fetch from reset with decode always ready
    rst_n = 1'b1;
    inst_ready = 1'b1;
    #1;
    chk("seq_ra0", 32'(read_addr), 32'h0010_0000);
    step();
    chk("seq_ra1", 32'(read_addr), 32'h0010_0001);
    chk("seq_valid1", 32'(inst_valid), 32'd1);
    chk("seq_inst1", inst, 32'h2008_0001);
    chk("seq_pc1", inst_pc, 32'h0040_0000);
    step();
    chk("seq_ra2", 32'(read_addr), 32'h0010_0002);
    chk("seq_inst2", inst, 32'h2009_0002);
    chk("seq_pc2", inst_pc, 32'h0040_0004);
    step();
    chk("seq_inst3", inst, 32'h0109_5020);
    chk("seq_pc3", inst_pc, 32'h0040_0008);

    // Backpressure straight after reset: buffer fills, pc parks at +8
    rst_n = 1'b0;
    inst_ready = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("stall_ra", 32'(read_addr), 32'h0010_0002);
    chk("stall_inst", inst, 32'h2008_0001);
    chk("stall_pc", inst_pc, 32'h0040_0000);
    inst_ready = 1'b1;
    step();
    chk("release_pc1", inst_pc, 32'h0040_0004);
    step();
    chk("release_pc2", inst_pc, 32'h0040_0008);

    // Redirect with a full buffer flushes old entries
    inst_ready = 1'b0;
    repeat (3) step();
    chk("full_valid", 32'(inst_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0040_0013;
    step();
    redirect_valid = 1'b0;
    chk("flush_valid", 32'(inst_valid), 32'd0);
    wait_valid();
    chk("redir_pc", inst_pc, 32'h0040_0010);
    chk("redir_inst", inst, mem_word(32'h0040_0010));

    // Toggle ready at full occupancy: pc advances only on pop cycles
    repeat (3) step();
    for (int k = 0; k < 12; k++) begin
      ra0 = read_addr;
      r = (k % 2 == 0);
      inst_ready = r;
      step();
      chk("toggle_valid", 32'(inst_valid), 32'd1);
      chk("toggle_ra", 32'(read_addr), 32'(ra0 + (r ? 30'd1 : 30'd0)));
    end

    // Wrap at the top of the address space
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    wait_valid();
    chk("wrap_pc0", inst_pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc1", inst_pc, 32'h0000_0000);

    // Short asynchronous reset pulse with entries buffered
    inst_ready = 1'b0;
    repeat (3) step();
    chk("pre_pulse_valid", 32'(inst_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("pulse_valid_drop", 32'(inst_valid), 32'd0);
    chk("pulse_read_addr", 32'(read_addr), 32'h0010_0000);
    #4 rst_n = 1'b1;
    step();
    chk("pulse_restart_valid", 32'(inst_valid), 32'd1);
    chk("pulse_restart_pc", inst_pc, 32'h0040_0000);
    inst_ready = 1'b1;

    // Random ready, redirects (some near the wrap point) and occasional reset pulses
    for (int n = 0; n < 3000; n++) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFE0 + 32'($urandom_range(0, 31))
                                                : 32'($urandom);
      if (n % 700 == 350) begin
        redirect_valid = 1'b0;
        #1 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
      step();
    end
    redirect_valid = 1'b0;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0040_0000, giving the byte address of the first fetch after reset.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The module SHALL have port read_addr, output, 30 bits: word address driven to instruction memory, equal to pc[31:2].
REQ-005 The module SHALL have port memout, input, 32 bits: instruction word returned by instruction memory in the same cycle (combinational read).
REQ-006 The module SHALL have port redirect_valid, input, 1 bit: request to restart fetch at redirect_pc (branch/jump).
REQ-007 The module SHALL have port redirect_pc, input, 32 bits: new fetch byte address; bits [1:0] ignored.
REQ-008 The module SHALL have port inst_valid, output, 1 bit: the head of the instruction buffer is valid.
REQ-009 The module SHALL have port inst, output, 32 bits: instruction word at the buffer head.
REQ-010 The module SHALL have port inst_pc, output, 32 bits: byte address of inst.
REQ-011 The module SHALL have port inst_ready, input, 1 bit: the decode stage accepts the head this cycle.

Function
REQ-012 pc SHALL be a 32-bit register; read_addr SHALL be pc[31:2] combinationally, every cycle.
REQ-013 The buffer SHALL be a 2-entry FIFO of {pc, instruction} pairs with a 2-bit occupancy count of 0..2.
REQ-014 pop SHALL be inst_valid && inst_ready; inst_valid SHALL be (count != 0); inst/inst_pc SHALL show the head entry, driven from registers with no combinational path from memout.
REQ-015 push SHALL be !redirect_valid && (count < 2 || pop); on push, {pc, memout} SHALL be written at the tail and pc SHALL become pc + 4.
REQ-016 With no push, pc SHALL hold its value, and read_addr SHALL stay stable.
REQ-017 Push and pop in the same cycle SHALL leave count unchanged, including at count 2 (full).
REQ-018 Latency: an instruction fetched in cycle N SHALL be presented with inst_valid high in cycle N+1 at the earliest.
REQ-019 Sustained throughput SHALL be one instruction per cycle while inst_ready is held high.
REQ-020 On redirect_valid, the buffer SHALL be flushed (count to 0), pc SHALL become {redirect_pc[31:2], 2'b00}, and no push SHALL occur that cycle.
REQ-021 A pop in the same cycle as a redirect SHALL still be accepted by decode; the flush overrides it.
REQ-022 pc + 4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC to 32'h0000_0000) with no error indication.
REQ-023 Empty buffer with inst_ready high SHALL not pop; the count SHALL never underflow or exceed 2.

Reset
REQ-024 On rst_n low, asynchronously: pc = RESET_PC, count = 0, head/tail pointers = 0, inst_valid = 0; inst and inst_pc SHALL be 32'h0.
REQ-025 Reset asserted mid-operation SHALL discard all buffered entries; the first fetch after release SHALL be from RESET_PC (read_addr 30'h0010_0000 at default).

Structure
REQ-026 A shared package SHALL hold RESET_PC_DEFAULT, INST_W = 32, ADDR_W = 32, and the fetch-entry struct {pc, inst}.
REQ-027 The FIFO SHALL be a sub-module fetch_buffer (depth 2, push/pop/flush, count output); inst_fetch holds pc and the push/redirect control.

Verification
REQ-028 Reset release with memory words 0x20080001, 0x20090002, 0x01095020 at byte 0x0040_0000.. and inst_ready = 1 -> read_addr 0x0010_0000, 0x0010_0001, 0x0010_0002 on consecutive cycles; inst/inst_pc = 0x20080001/0x0040_0000, then 0x20090002/0x0040_0004, then 0x01095020/0x0040_0008, one per cycle.
REQ-029 inst_ready = 0 for 5 cycles after reset -> count saturates at 2; pc stops at 0x0040_0008; inst holds 0x20080001; on release, no instruction is lost or duplicated.
REQ-030 redirect_valid with redirect_pc = 0x0040_0013 while the buffer is full -> the next inst_valid shows inst_pc = 0x0040_0010; the old entries never appear.
REQ-031 Toggling inst_ready every cycle at full occupancy -> the inst_pc sequence is strictly +4 with no gaps, and simultaneous push/pop keeps count = 2.
REQ-032 Redirect to 0xFFFF_FFFC -> the next two inst_pc values are 0xFFFF_FFFC then 0x0000_0000.
REQ-033 rst_n pulsed low for half a cycle with 2 entries buffered -> inst_valid drops immediately, and fetch restarts at 0x0040_0000.
